// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between NREQ requesters and the register-file write arbiter.
// Carries the request handshake, the stall input and the registered write outputs.
interface regfile_write_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wr_stall;
  logic                   ctrl_writeEnable;
  logic [ADDR_W-1:0]      ctrl_writeReg;
  logic [DATA_W-1:0]      data_writeReg;
  logic [2:0]             grant_id;
  logic [7:0]             drop_count;

  modport master (
    output req_valid, req_addr, req_data, wr_stall,
    input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, drop_count
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall,
    output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, drop_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters,
// with a registered write stage, register-0 filtering and downstream stall.

module regfile_write_arbiter_lane #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              is_zero
);
  assign addr    = addr_in;
  assign data    = data_in;
  assign is_zero = (addr_in == '0);
endmodule

module regfile_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clock,
  input  logic                   ctrl_reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int                PTR_W  = $clog2(NREQ);
  localparam logic [PTR_W:0]    NREQ_L = (PTR_W+1)'(NREQ);
  localparam logic [NREQ-1:0]   ONE    = NREQ'(1);

  logic [NREQ-1:0][ADDR_W-1:0] lane_addr;
  logic [NREQ-1:0][DATA_W-1:0] lane_data;
  logic [NREQ-1:0]             lane_zero;

  logic [PTR_W-1:0]  ptr, off, sel, ptr_nxt;
  logic [PTR_W:0]    sum, inc;
  logic [2*NREQ-1:0] dbl;
  logic              xfer;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    regfile_write_arbiter_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane (
      .addr_in (bus.req_addr[i*ADDR_W +: ADDR_W]),
      .data_in (bus.req_data[i*DATA_W +: DATA_W]),
      .addr    (lane_addr[i]),
      .data    (lane_data[i]),
      .is_zero (lane_zero[i])
    );
  end

  // Rotate the valid vector so ptr sits at bit 0; the lowest set bit is the winner's offset.
  always_comb begin
    dbl = {bus.req_valid, bus.req_valid} >> ptr;
    off = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (dbl[k]) off = PTR_W'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_L) sum = sum - NREQ_L;
    sel = sum[PTR_W-1:0];
    inc = {1'b0, sel} + 1'b1;
    if (inc == NREQ_L) inc = '0;
    ptr_nxt = inc[PTR_W-1:0];
  end

  assign xfer          = (|bus.req_valid) & ~bus.wr_stall;
  assign bus.req_ready = (xfer && ctrl_reset_n) ? (ONE << sel) : '0;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ptr                  <= '0;
      bus.ctrl_writeEnable <= 1'b0;
      bus.ctrl_writeReg    <= '0;
      bus.data_writeReg    <= '0;
      bus.grant_id         <= '0;
      bus.drop_count       <= '0;
    end else begin
      bus.ctrl_writeEnable <= xfer & ~lane_zero[sel];
      if (xfer) begin
        ptr          <= ptr_nxt;
        bus.grant_id <= 3'(sel);
        if (!lane_zero[sel]) begin
          bus.ctrl_writeReg <= lane_addr[sel];
          bus.data_writeReg <= lane_data[sel];
        end else if (bus.drop_count != 8'hFF) begin
          bus.drop_count <= bus.drop_count + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a negedge model predicts ready and
// the next registered write; directed phases cover reset, round-robin, reg-0, stall.
module tb_regfile_write_arbiter;
  localparam int NREQ = 4, ADDR_W = 5, DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [2:0]        g;
    logic [7:0]        drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0, n_err = 0;

  exp_t q[$];
  int   m_ptr = 0;
  exp_t m = '0;

  regfile_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock        (clk),
    .ctrl_reset_n (rst_n),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.req_valid[i]                 = v;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Reference model: compare the write registered at the last edge, then predict this cycle.
  always @(negedge clk) begin
    exp_t e;
    int g, j;
    logic [NREQ-1:0] er;
    logic [ADDR_W-1:0] a;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
      m = '0;
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_we", bus.ctrl_writeEnable, 0);
      chk("rst_drop", bus.drop_count, 0);
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("we",   bus.ctrl_writeEnable, e.we);
        chk("waddr", bus.ctrl_writeReg,   e.a);
        chk("wdata", bus.data_writeReg,   e.d);
        chk("gid",  bus.grant_id,         e.g);
        chk("drop", bus.drop_count,       e.drop);
      end
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
      er = '0;
      if (g >= 0 && !bus.wr_stall) er[g] = 1'b1;
      chk("ready", bus.req_ready, er);
      m.we = 1'b0;
      if (er != '0) begin
        m.g   = 3'(g);
        m_ptr = (g == NREQ-1) ? 0 : g + 1;
        a = bus.req_addr[g*ADDR_W +: ADDR_W];
        if (a != '0) begin
          m.we = 1'b1;
          m.a  = a;
          m.d  = bus.req_data[g*DATA_W +: DATA_W];
        end else if (m.drop != 8'hFF) begin
          m.drop = m.drop + 8'd1;
        end
      end
      q.push_back(m);
    end
  end

  initial begin
    bus.wr_stall = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDR_W'(i + 1), 32'hA000_0000 + i);

    // Reset held with all valid, then release: requester 0 first.
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("first_gid", bus.grant_id, 0);
    chk("first_we", bus.ctrl_writeEnable, 1);

    // Single requester 2.
    bus.req_valid = 4'b0100;
    set_req(2, 1'b1, 5'd7, 32'hDEADBEEF);
    #1 chk("single_ready", bus.req_ready, 4'b0100);
    step();
    chk("single_addr", bus.ctrl_writeReg, 7);
    chk("single_data", bus.data_writeReg, 32'hDEADBEEF);
    chk("single_gid", bus.grant_id, 2);

    // Round-robin, all valid for 8 cycles.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDR_W'(i + 1), $urandom);
    repeat (8) begin
      step();
      for (int i = 0; i < NREQ; i++) bus.req_data[i*DATA_W +: DATA_W] = $urandom;
    end

    // Register-0 filter on requester 1.
    bus.req_valid = '0;
    step();
    bus.req_valid = 4'b0010;
    set_req(1, 1'b1, 5'd0, 32'h12345678);
    step();
    chk("r0_we", bus.ctrl_writeEnable, 0);
    chk("r0_drop1", bus.drop_count, 1);
    repeat (299) step();
    bus.req_valid = '0;
    step();
    chk("r0_sat", bus.drop_count, 255);

    // Stall with ptr=2 (last transfer from requester 1).
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDR_W'(i + 9), $urandom);
    bus.wr_stall = 1'b1;
    repeat (3) begin
      step();
      chk("stall_we", bus.ctrl_writeEnable, 0);
    end
    bus.wr_stall = 1'b0;
    step();
    chk("unstall_gid", bus.grant_id, 2);

    // Mid-operation reset while a write from requester 2 is registered (ptr=3).
    bus.req_valid = 4'b0100;
    step();
    chk("pre_rst_we", bus.ctrl_writeEnable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", bus.ctrl_writeEnable, 0);
    chk("mid_rst_addr", bus.ctrl_writeReg, 0);
    chk("mid_rst_data", bus.data_writeReg, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    bus.req_valid = 4'b1111;
    step();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", bus.req_ready, 4'b0001);
    repeat (3) step();
    bus.req_valid = '0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
